id_entry_capture: RTL

- Upstream stage of the user-ID check. Builds a 16-bit user ID from four hex digits set on switches and committed with a push button.
- Presents the ID as entered[15:0] with valid_bit to the ID-control stage, and holds both stable until log_out.
- Debounces the raw buttons, supports clear, and abandons a partial entry after an idle timeout.

---
 rtl/id_entry_capture_pkg.sv | 14 +
 rtl/id_entry_capture_btn_debounce.sv | 48 ++++
 rtl/id_entry_capture.sv | 126 ++++++++++++
 3 files changed

// File: rtl/id_entry_capture_pkg.sv
// Shared types and sizes for the user-ID entry stage.
package id_entry_capture_pkg;

  localparam int ID_DIGITS = 4;
  localparam int ID_WIDTH  = 16;
  localparam int DIGIT_W   = ID_WIDTH / ID_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } state_e;

endpackage

// File: rtl/id_entry_capture_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: reset is sampled on the clock edge, and every register here is
  // written with <= so all flops update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      pulse_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        // The Nth consecutive differing sample flips the level.
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          pulse_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/id_entry_capture.sv
// Collects four hex digits into a user ID and holds it until log_out.
module id_entry_capture
  import id_entry_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [DIGIT_W-1:0]  digit_sw,
  input  logic                enter_btn,
  input  logic                clear_btn,
  input  logic                log_out,
  output logic [ID_WIDTH-1:0] entered,
  output logic                valid_bit,
  output logic [2:0]          digit_count,
  output logic                timeout_flag
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic enter_pulse, clear_pulse;
  logic unused_enter_level, unused_clear_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clock     (clock),
    .rst       (rst),
    .btn_raw   (enter_btn),
    .btn_level (unused_enter_level),
    .btn_pulse (enter_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clock     (clock),
    .rst       (rst),
    .btn_raw   (clear_btn),
    .btn_level (unused_clear_level),
    .btn_pulse (clear_pulse)
  );

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] entered_q, entered_d;
  logic [2:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic                tflag_q, tflag_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q   <= IDLE;
      entered_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      tflag_q   <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      tflag_q   <= tflag_d;
      tmr_q     <= tmr_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    count_d   = count_q;
    valid_d   = valid_q;
    tflag_d   = 1'b0;
    tmr_d     = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (log_out || clear_pulse) begin
          entered_d = '0;
        end else if (enter_pulse) begin
          entered_d = {entered_q[ID_WIDTH-DIGIT_W-1:0], digit_sw};
          count_d   = 3'd1;
          tmr_d     = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (log_out || clear_pulse) begin
          entered_d = '0;
          count_d   = '0;
          state_d   = IDLE;
        end else if (enter_pulse) begin
          entered_d = {entered_q[ID_WIDTH-DIGIT_W-1:0], digit_sw};
          count_d   = count_q + 3'd1;
          tmr_d     = '0;
          if (count_q == 3'(ID_DIGITS - 1)) begin
            valid_d = 1'b1;
            state_d = READY;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          entered_d = '0;
          count_d   = '0;
          tflag_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      READY: begin
        // Clearing on log_out keeps the checker from re-triggering on a stale ID.
        if (log_out) begin
          entered_d = '0;
          count_d   = '0;
          valid_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign entered      = entered_q;
  assign valid_bit    = valid_q;
  assign digit_count  = count_q;
  assign timeout_flag = tflag_q;

endmodule
